// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store bus adapter.
//   Accepts one load or store per instruction, drives a registered single-beat
//   bus request, waits for MemAck (bounded by TIMEOUT cycles), formats load data
//   and stalls the pipeline until the access finishes.
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   MemWriteM, ResultSrcM, TypeM  access kind (store / load / funct3 width)
//   ALUResultM, WriteDataM        byte address and right-aligned store data
//   MemReq, MemWe, MemAddr,
//   MemWData, MemBE               registered bus request
//   MemAck, MemRData              bus completion strobe and read data
//   ReadDataM                     registered, formatted load result
//   StallM                        pipeline freeze (combinational)
//   MisalignM, BusErrM            misaligned/illegal access, bus timeout
module mem_access_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MemWriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic [2:0]       TypeM,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] WriteDataM,
  output logic             MemReq,
  output logic             MemWe,
  output logic [WIDTH-1:0] MemAddr,
  output logic [WIDTH-1:0] MemWData,
  output logic [3:0]       MemBE,
  input  logic             MemAck,
  input  logic [WIDTH-1:0] MemRData,
  output logic [WIDTH-1:0] ReadDataM,
  output logic             StallM,
  output logic             MisalignM,
  output logic             BusErrM
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  // Counter value on the last REQ cycle allowed before declaring a timeout.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [2:0]       type_q, type_d;
  logic [1:0]       off_q, off_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             buserr_q, buserr_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             acc;
  logic             ill;
  logic [1:0]       off;
  logic [WIDTH-1:0] st_wdata;
  logic [3:0]       st_be;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [WIDTH-1:0] ld_fmt;

  assign acc = MemWriteM | (ResultSrcM == 2'b01);
  assign off = ALUResultM[1:0];

  always_comb begin
    ill = 1'b0;
    case (TypeM)
      3'b001, 3'b101:         ill = off[0];
      3'b010:                 ill = (off != 2'b00);
      3'b011, 3'b110, 3'b111: ill = 1'b1;
      default:                ill = 1'b0;
    endcase
  end

  // Store lane replication; TypeM[1:0] selects byte/half/word.
  always_comb begin
    st_wdata = WriteDataM;
    st_be    = 4'hF;
    case (TypeM[1:0])
      2'b00: begin
        st_wdata = {4{WriteDataM[7:0]}};
        st_be    = 4'b0001 << off;
      end
      2'b01: begin
        st_wdata = {2{WriteDataM[15:0]}};
        st_be    = off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = WriteDataM;
        st_be    = 4'hF;
      end
    endcase
  end

  // Load formatting uses the width and offset captured at acceptance.
  always_comb begin
    ld_byte = MemRData[7:0];
    case (off_q)
      2'b00:   ld_byte = MemRData[7:0];
      2'b01:   ld_byte = MemRData[15:8];
      2'b10:   ld_byte = MemRData[23:16];
      default: ld_byte = MemRData[31:24];
    endcase
    ld_half = off_q[1] ? MemRData[31:16] : MemRData[15:0];
    case (type_q)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'b0, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {16'b0, ld_half};
      default: ld_fmt = MemRData;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    type_d   = type_q;
    off_d    = off_q;
    rdata_d  = rdata_q;
    buserr_d = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (acc && !ill) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          we_d    = MemWriteM;
          addr_d  = {ALUResultM[WIDTH-1:2], 2'b00};
          if (MemWriteM) begin
            wdata_d = st_wdata;
            be_d    = st_be;
          end else begin
            be_d    = 4'hF;
          end
          type_d  = TypeM;
          off_d   = off;
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        // Ack is tested first so it wins over a coincident timeout.
        if (MemAck) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          if (!we_q) rdata_d = ld_fmt;
        end else if (cnt_q == TO_LAST) begin
          state_d  = S_DONE;
          req_d    = 1'b0;
          rdata_d  = '0;
          buserr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      type_q   <= '0;
      off_q    <= '0;
      rdata_q  <= '0;
      buserr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      type_q   <= type_d;
      off_q    <= off_d;
      rdata_q  <= rdata_d;
      buserr_q <= buserr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign MemReq    = req_q;
  assign MemWe     = we_q;
  assign MemAddr   = addr_q;
  assign MemWData  = wdata_q;
  assign MemBE     = be_q;
  assign ReadDataM = rdata_q;
  assign BusErrM   = buserr_q;
  assign StallM    = ((state_q == S_IDLE) && acc && !ill) || (state_q == S_REQ);
  assign MisalignM = (state_q == S_IDLE) && acc && ill;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, the data/address width; only 32 is supported.
REQ-002 The module SHALL have parameter TIMEOUT, default 255, the maximum cycles to wait for MemAck; legal range 1-255.
REQ-003 CLK  input  1  the single clock; all state SHALL update on the posedge.
REQ-004 RST  input  1  reset; asynchronous and active-high.
REQ-005 MemWriteM  input  1  store request from the M stage.
REQ-006 ResultSrcM  input  2  the value 2'b01 marks a load.
REQ-007 TypeM  input  3  funct3 access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 ALUResultM  input  WIDTH  byte address of the access.
REQ-009 WriteDataM  input  WIDTH  store data, right-aligned.
REQ-010 MemReq, MemWe  output  1 each  bus request and write enable, both registered.
REQ-011 MemAddr  output  WIDTH  word address ({ALUResultM[31:2],2'b00}), registered.
REQ-012 MemWData  output  WIDTH  lane-replicated store data, registered.
REQ-013 MemBE  output  4  byte enables, registered.
REQ-014 MemAck  input  1  one-cycle completion strobe; MemRData  input  WIDTH  valid when MemAck=1.
REQ-015 ReadDataM  output  WIDTH  formatted load result, registered.
REQ-016 StallM  output  1  freezes the pipeline (combinational).
REQ-017 MisalignM, BusErrM  output  1 each  exception flags.

Function
REQ-018 Access: Acc = MemWriteM | (ResultSrcM==2'b01); a store takes priority if both are set.
REQ-019 Illegal: Ill = H/HU with addr[0]=1, W with addr[1:0]!=0, or TypeM in {011,110,111}.
REQ-020 The FSM SHALL have states IDLE, REQ and DONE.
REQ-021 IDLE transitions:
  - Acc & !Ill: go to REQ and register MemReq=1, MemWe, MemAddr, MemWData and MemBE, plus the captured TypeM and addr[1:0]; clear the timeout counter.
  - Acc & Ill: stay in IDLE; MisalignM=1 combinationally; no bus request.
REQ-022 REQ: all bus outputs SHALL be held stable; on MemAck=1, go to DONE, MemReq<=0, ReadDataM<=formatted MemRData (loads only).
REQ-023 REQ timeout: if the counter reaches TIMEOUT without MemAck, go to DONE, MemReq<=0, ReadDataM<=0, BusErrM<=1 for the DONE cycle.
REQ-024 A MemAck arriving in the same cycle the counter reaches TIMEOUT SHALL win; BusErrM stays 0.
REQ-025 DONE SHALL return to IDLE unconditionally after one cycle; no new access is accepted in DONE.
REQ-026 StallM = (IDLE & Acc & !Ill) | REQ; StallM=0 in DONE, so the pipeline advances exactly once per access.
REQ-027 Store lanes:
  - SB: MemWData={4{WriteDataM[7:0]}}, MemBE=4'b0001<<addr[1:0].
  - SH: MemWData={2{WriteDataM[15:0]}}, MemBE=addr[1]?1100:0011.
  - SW: MemWData=WriteDataM, MemBE=1111.
REQ-028 Loads SHALL drive MemWe=0 and MemBE=1111.
REQ-029 Load formatting: select byte/half by the captured addr bits; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-030 ReadDataM SHALL hold its value until the next completed load, timeout or reset.
REQ-031 MemAck received outside REQ SHALL be ignored.
REQ-032 Latency: request visible 1 cycle after acceptance; ReadDataM valid in DONE, 1 cycle after MemAck.

Reset
REQ-033 RST=1 SHALL immediately force state=IDLE and MemReq=0, MemWe=0, MemBE=0, MemAddr=0, MemWData=0, ReadDataM=0, BusErrM=0 and counter=0, including mid-REQ; an outstanding transaction is abandoned.
REQ-034 While RST=1, StallM and MisalignM SHALL follow their combinational definitions with state=IDLE.

Verification
REQ-035 LB at addr 0x103, MemRData=0x80FF_FF00, ack after 3 cycles -> MemBE=1111, MemAddr=0x100; ReadDataM=0xFFFF_FF80; StallM high 4 cycles then low in DONE.
REQ-036 SH at 0x202, WriteDataM=0x1234_ABCD -> MemWData=0xABCD_ABCD, MemBE=1100, MemWe=1.
REQ-037 LW at 0x101 -> MisalignM=1, StallM=0, MemReq stays 0.
REQ-038 LHU at 0x0, no ack with TIMEOUT=4 -> MemReq drops after 4 REQ cycles; BusErrM=1 for one cycle; ReadDataM=0.
REQ-039 RST asserted during REQ -> MemReq=0 in the same cycle; after release, a new SW completes normally.
REQ-040 Back-to-back LW then SW, each acked in 1 cycle -> exactly one bus request per instruction; no re-issue in DONE.
